// File: rtl/clk_meter_pkg.sv
// Shared definitions for the clock frequency meter.
//   state_t      : measurement FSM states (IDLE, MEASURE, DONE)
//   EDGE_W_DEF   : default edge-counter width
//   EDGE_MAX_DEF : saturation value of a default-width edge counter
//   sat_inc      : saturating-increment helper on a default-width counter
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int unsigned EDGE_W_DEF   = 32;
  localparam logic [EDGE_W_DEF-1:0] EDGE_MAX_DEF = '1;

  // Saturating increment; returns the value unchanged once at EDGE_MAX_DEF.
  function automatic logic [EDGE_W_DEF-1:0] sat_inc(input logic [EDGE_W_DEF-1:0] v);
    return (v == EDGE_MAX_DEF) ? v : v + EDGE_W_DEF'(1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous input.
//   clk      : sampling clock
//   rst      : asynchronous active-low reset
//   async_i  : asynchronous input
//   s_in_o   : synchronised level
//   rise_o   : one-cycle pulse on a synchronised 0->1 transition
// Input-to-rise latency is 2-3 clk cycles depending on sampling phase.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic s_in_o,
  output logic rise_o
);

  logic sync1_q, s_in_q, s_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      s_in_q   <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      sync1_q  <= async_i;
      s_in_q   <= sync1_q;
      s_prev_q <= s_in_q;
    end
  end

  assign s_in_o = s_in_q;
  assign rise_o = s_in_q & ~s_prev_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Gated edge counter: counts rising edges of clk_in over GATE_CYCLES cycles
// of clk and publishes the result with a one-cycle done pulse.
//   clk, rst    : board clock, asynchronous active-low reset
//   clk_in      : signal under measurement (asynchronous to clk)
//   start       : request a measurement (accepted only in IDLE, not with abort)
//   abort       : cancel a measurement in progress
//   busy        : high while measuring
//   done        : one-cycle pulse when count/overflow are updated
//   count       : rising edges seen in the last completed window
//   overflow    : last completed window saturated the edge counter
//   high_cnt    : cycles with clk_in high in the last window
//                 (only when CLK_METER_DUTY_EN is defined)
module clk_freq_meter
  import clk_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 1000000,
  parameter int GATE_W      = 32,
  parameter int EDGE_W      = EDGE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_in,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [EDGE_W-1:0] count,
  output logic              overflow
`ifdef CLK_METER_DUTY_EN
  ,
  output logic [EDGE_W-1:0] high_cnt
`endif
);

  localparam logic [EDGE_W-1:0] EDGE_MAX  = {EDGE_W{1'b1}};
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);

  logic s_in, rise;

  sync_edge_det u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (clk_in),
    .s_in_o  (s_in),
    .rise_o  (rise)
  );

  state_t            state_q;
  logic [GATE_W-1:0] gate_q;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, done_q, overflow_q;
  logic [EDGE_W-1:0] count_q;

  // Saturating edge count; an increment attempted at max sets the sticky flag.
  always_comb begin
    edge_d = edge_q;
    ovf_d  = ovf_q;
    if (rise) begin
      if (edge_q == EDGE_MAX) ovf_d  = 1'b1;
      else                    edge_d = edge_q + EDGE_W'(1);
    end
  end

`ifdef CLK_METER_DUTY_EN
  logic [EDGE_W-1:0] hi_q, hi_d, high_q;

  always_comb begin
    hi_d = hi_q;
    if (s_in && hi_q != EDGE_MAX) hi_d = hi_q + EDGE_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q   <= '0;
      high_q <= '0;
    end else begin
      case (state_q)
        IDLE:    if (start && !abort) hi_q <= '0;
        MEASURE: if (!abort) begin
          hi_q <= hi_d;
          if (gate_q == '0) high_q <= hi_d;
        end
        default: ;
      endcase
    end
  end

  assign high_cnt = high_q;
`else
  logic unused_s_in;
  assign unused_s_in = s_in;
`endif

  // The result is latched on the edge that enters DONE, so done/count are
  // visible during the DONE cycle itself: GATE_CYCLES+1 cycles after accept.
  // The last window cycle's edge is folded in via edge_d/ovf_d.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gate_q     <= '0;
      edge_q     <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            gate_q  <= GATE_LOAD;
            edge_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          if (abort) begin
            // Edge in this cycle is dropped; published result untouched.
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            edge_q <= edge_d;
            ovf_q  <= ovf_d;
            if (gate_q == '0) begin
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              count_q    <= edge_d;
              overflow_q <= ovf_d;
              state_q    <= DONE;
            end else begin
              gate_q <= gate_q - GATE_W'(1);
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
module tb_clk_freq_meter;

  localparam int G = 96;

  logic        clk = 1'b0, rst = 1'b0, clk_in = 1'b0, start = 1'b0, abort = 1'b0;
  logic        busy, done, overflow;
  logic [31:0] count;
  logic        busy4, done4, overflow4;
  logic [3:0]  count4;
`ifdef CLK_METER_DUTY_EN
  logic [31:0] high;
  logic [3:0]  high4;
`endif

  clk_freq_meter #(.GATE_CYCLES(G), .GATE_W(8), .EDGE_W(32)) dut (
    .clk(clk), .rst(rst), .clk_in(clk_in), .start(start), .abort(abort),
    .busy(busy), .done(done), .count(count), .overflow(overflow)
`ifdef CLK_METER_DUTY_EN
    , .high_cnt(high)
`endif
  );

  clk_freq_meter #(.GATE_CYCLES(G), .GATE_W(8), .EDGE_W(4)) dut4 (
    .clk(clk), .rst(rst), .clk_in(clk_in), .start(start), .abort(abort),
    .busy(busy4), .done(done4), .count(count4), .overflow(overflow4)
`ifdef CLK_METER_DUTY_EN
    , .high_cnt(high4)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // clk_in pattern: 0 low, 1 high, 2 toggle every 4 clk, 3 toggle every clk
  int mode = 0;
  int ph   = 0;
  always @(negedge clk) begin
    case (mode)
      0: clk_in = 1'b0;
      1: clk_in = 1'b1;
      2: if (ph % 4 == 0) clk_in = ~clk_in;
      default: clk_in = ~clk_in;
    endcase
    ph = ph + 1;
  end

  typedef struct {
    int          cyc;
    logic [31:0] c;
    logic        o;
    logic [3:0]  c4;
    logic        o4;
    logic [31:0] h;
    logic [3:0]  h4;
  } exp_t;
  exp_t q[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pops the oldest expectation.
  always @(negedge clk) begin
    if (rst && (done === 1'b1 || done4 === 1'b1)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("done_both", {done, done4}, 2'b11);
        chk("count", count, e.c);
        chk("overflow", overflow, e.o);
        chk("count_w4", count4, e.c4);
        chk("overflow_w4", overflow4, e.o4);
`ifdef CLK_METER_DUTY_EN
        chk("high_cnt", high, e.h);
        chk("high_cnt_w4", high4, e.h4);
`endif
      end
    end
  end

  task automatic launch(input int m, input logic push,
                        input logic [31:0] c, input logic o,
                        input logic [3:0] c4, input logic o4,
                        input logic [31:0] h, input logic [3:0] h4,
                        output int acc);
    exp_t e;
    mode = m;
    repeat (12) @(negedge clk);
    start = 1'b1;
    acc   = cyc;
    if (push) begin
      e.cyc = acc + G + 1; e.c = c; e.o = o; e.c4 = c4; e.o4 = o4; e.h = h; e.h4 = h4;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int acc;
    int w;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", count, 32'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_count_w4", count4, 4'd0);
    rst = 1'b1;

    // Period 8
    launch(2, 1'b1, 32'd12, 1'b0, 4'd12, 1'b0, 32'd48, 4'd15, acc);
    repeat (G + 4) @(negedge clk);
    // Period 2: saturates the 4-bit instance
    launch(3, 1'b1, 32'd48, 1'b0, 4'd15, 1'b1, 32'd48, 4'd15, acc);
    repeat (G + 4) @(negedge clk);
    // Held low / held high
    launch(0, 1'b1, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 4'd0, acc);
    repeat (G + 4) @(negedge clk);
    launch(1, 1'b1, 32'd0, 1'b0, 4'd0, 1'b0, 32'd96, 4'd15, acc);
    repeat (G + 4) @(negedge clk);

    // Abort at window cycle 40 after a count=12 result
    launch(2, 1'b1, 32'd12, 1'b0, 4'd12, 1'b0, 32'd48, 4'd15, acc);
    repeat (G + 4) @(negedge clk);
    launch(2, 1'b0, 0, 0, 0, 0, 0, 0, acc);
    repeat (39) @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy_after", busy, 1'b0);
    repeat (G) @(negedge clk);
    chk("abort_count_held", count, 32'd12);
    chk("abort_overflow_held", overflow, 1'b0);

    // start during MEASURE is ignored: exactly one done
    launch(3, 1'b1, 32'd48, 1'b0, 4'd15, 1'b1, 32'd48, 4'd15, acc);
    repeat (29) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (G) @(negedge clk);

    // start together with abort in IDLE is ignored
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("start_abort_busy", busy, 1'b0);
      @(negedge clk);
    end
    repeat (G) @(negedge clk);

    // Reset at window cycle 50, after a count=12 result
    launch(2, 1'b1, 32'd12, 1'b0, 4'd12, 1'b0, 32'd48, 4'd15, acc);
    repeat (G + 4) @(negedge clk);
    launch(2, 1'b0, 0, 0, 0, 0, 0, 0, acc);
    repeat (49) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_count", count, 32'd0);
    chk("midrst_overflow", overflow, 1'b0);
    chk("midrst_count_w4", count4, 4'd0);
`ifdef CLK_METER_DUTY_EN
    chk("midrst_high", high, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    repeat (G) @(negedge clk);
    launch(2, 1'b1, 32'd12, 1'b0, 4'd12, 1'b0, 32'd48, 4'd15, acc);

    // Drain scoreboard with a bounded wait
    w = 0;
    while (q.size() > 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL missing_done actual=%0d expected=0 pending", q.size());
    end
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_freq_meter.md
Name: clk_freq_meter

Overview:
- Measures the rate of a divided or slow clock signal, such as the CPU clock produced by the board's clock divider, against the fast board clock.
- Counts rising edges of `clk_in` over a fixed gate window of `GATE_CYCLES` board-clock cycles, then publishes the count with a one-cycle `done` pulse.
- Used by debug and display logic to confirm which CPU clock rate is selected.

Parameters:
- GATE_CYCLES, 1000000, length of the measurement window in `clk` cycles; must be ≥ 2.
- GATE_W, 32, width of the internal gate down-counter; must satisfy 2^GATE_W > GATE_CYCLES.
- EDGE_W, 32, width of the edge counter and of `count`.

Ports:
- clk  in  1  board clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- clk_in  in  1  signal under measurement; asynchronous to `clk`.
- start  in  1  request a measurement; sampled only in IDLE.
- abort  in  1  cancel the measurement in progress.
- busy  out  1  high while in MEASURE.
- done  out  1  one-cycle pulse when a new result is latched.
- count  out  EDGE_W  rising-edge count from the last completed window.
- overflow  out  1  the last completed window saturated the edge counter.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; both synchroniser flops, the edge-detect flop, the gate counter, the edge counter, `busy`, `done`, `count` and `overflow` all go to 0.
- Synchroniser: two-flop synchroniser on `clk_in` gives `s_in`; a third flop `s_prev` holds the previous value.
  - `rise = s_in & ~s_prev`.
  - Input-to-detection latency is 2–3 `clk` cycles.
- States:
  - IDLE:
    - On `start=1` and `abort=0`: load gate counter with GATE_CYCLES-1, clear edge counter and its sticky overflow flag, go to MEASURE.
    - `start` together with `abort` is ignored.
  - MEASURE (`busy=1`), every cycle:
    - If `rise`: increment the edge counter, saturating at 2^EDGE_W-1. An increment attempted at the maximum sets the sticky internal overflow flag.
    - If gate counter = 0: go to DONE. Otherwise decrement the gate counter.
    - The window is therefore exactly GATE_CYCLES cycles. A `rise` in the last window cycle is counted.
    - If `abort=1`: go to IDLE immediately. `count`, `overflow` and `done` are unchanged, and the edge in that cycle is discarded.
    - `start` is ignored.
  - DONE (one cycle):
    - `count` ← edge counter, `overflow` ← sticky flag, `done=1`, go to IDLE.
    - `abort` in DONE has no effect.
- Timing: `done` is asserted GATE_CYCLES+1 cycles after the cycle in which `start` was accepted. `count` is valid from the `done` cycle and holds until the next `done`.
- `busy` is registered and equals (state==MEASURE).
- Back-to-back: `start` held high re-arms on the cycle after DONE, i.e. in IDLE.
- Reset asserted mid-window: immediate return to the reset values; no `done` is produced.

Optional Feature:
- Macro: CLK_METER_DUTY_EN.
- Defined:
  - Adds output port `high_cnt` (EDGE_W bits, reset 0).
  - During MEASURE, a second saturating counter increments in each window cycle where `s_in=1`.
  - It is latched to `high_cnt` in DONE, alongside `count`, and is unchanged on abort.
- Undefined: no port and no counter; behaviour is otherwise identical.

Decomposition:
- Shared package `clk_meter_pkg`: state enum (IDLE, MEASURE, DONE) and the localparam for the saturation maximum.
- One natural sub-module: `sync_edge_det`, containing the two-flop synchroniser, the previous-value flop and the `rise` output. It uses the same `clk` and active-low async `rst`.

Test Plan (bench GATE_CYCLES=96):
- `clk_in` toggling every 4 `clk` (period 8), `start` pulsed → `done` 97 cycles after accept, `count=12`, `overflow=0`. With CLK_METER_DUTY_EN, `high_cnt=48`.
- `clk_in` toggling every `clk` (period 2) → `count=48`. With EDGE_W=4 → `count=15`, `overflow=1`.
- `clk_in` held at 0, and separately held at 1 → `count=0`, `overflow=0`. With CLK_METER_DUTY_EN, `high_cnt` = 0 and 96 respectively.
- Complete one measurement with `count=12`, start a second, assert `abort` at window cycle 40 → no `done`, `busy` falls the next cycle, `count` stays 12.
- `start` pulsed during MEASURE, and `start` together with `abort` in IDLE → both ignored. Exactly one `done` for the original run; no run begins from the combined request.
- `rst` driven low for one cycle at window cycle 50 → all outputs 0 immediately, no `done`. A new `start` after release gives a correct result.
